// File: rtl/phase_incr_estimator.sv
// phase_incr_estimator
//   Measures the period of a signed sample stream, in step_in strobes between
//   rising zero crossings, then derives the equivalent oscillator phase
//   increment floor(2^32 / period) with a bit-serial restoring divider.
//   A crossing needs the waveform to have been armed first (a sample below
//   -HYST), so ripple around zero does not produce spurious crossings.
// Ports
//   clk_in, rst_in   clock, synchronous active-high reset
//   step_in          sample strobe, sample_in valid while high
//   sample_in        signed 32-bit waveform sample
//   period_out       last measured period (0 after a timeout)
//   phase_incr_out   floor(2^32/period_out), saturated; 0 after a timeout
//   valid_out        one-clock pulse whenever the outputs update
//   lock_out         a valid measurement is held
//   busy_out         divider running
//   overrun_out      sticky: a pending period was overwritten before its divide
module phase_incr_estimator #(
  parameter int PERIOD_W   = 16,
  parameter int MAX_PERIOD = 65535,
  parameter int HYST       = 2**24
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                step_in,
  input  logic signed [31:0]  sample_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic [31:0]         phase_incr_out,
  output logic                valid_out,
  output logic                lock_out,
  output logic                busy_out,
  output logic                overrun_out
);

  localparam logic [PERIOD_W-1:0] MAX_CNT  = PERIOD_W'(MAX_PERIOD);
  localparam logic signed [31:0]  NEG_HYST = -(32'(HYST));
  localparam logic [5:0]          LAST_IT  = 6'd32;  // 33 iterations: 0..32

  typedef enum logic {SEEK, MEASURE}    meas_e;
  typedef enum logic {DIV_IDLE, DIV_RUN} div_e;

  meas_e               meas_q, meas_d;
  div_e                div_q, div_d;
  logic                armed_q, armed_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                pend_full_q, pend_full_d;
  logic [PERIOD_W-1:0] pend_val_q, pend_val_d;
  logic [PERIOD_W-1:0] divisor_q, divisor_d;
  logic [PERIOD_W-1:0] rem_q, rem_d;
  logic [31:0]         quo_q, quo_d;
  logic [5:0]          iter_q, iter_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [31:0]         phase_q, phase_d;
  logic                valid_q, valid_d;
  logic                lock_q, lock_d;
  logic                overrun_q, overrun_d;

  logic                crossing, timeout, div_start, div_last, quo_bit;
  logic [PERIOD_W-1:0] cnt_inc, rem_nxt;
  logic [PERIOD_W:0]   trial, diff;
  logic [32:0]         quo_nxt;

  always_comb begin
    meas_d      = meas_q;
    div_d       = div_q;
    armed_d     = armed_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_val_d  = pend_val_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    iter_d      = iter_q;
    period_d    = period_q;
    phase_d     = phase_q;
    valid_d     = 1'b0;
    lock_d      = lock_q;
    overrun_d   = overrun_q;

    // Signed >= 0 is simply a clear sign bit.
    crossing = step_in && armed_q && !sample_in[31];
    cnt_inc  = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + 1'b1;
    timeout  = step_in && (meas_q == MEASURE) && !crossing && (cnt_inc == MAX_CNT);

    if (step_in) begin
      cnt_d = crossing ? {{(PERIOD_W-1){1'b0}}, 1'b1} : cnt_inc;
      if (crossing)                   armed_d = 1'b0;
      else if (sample_in < NEG_HYST)  armed_d = 1'b1;
    end

    // Restoring step; the dividend is 2^32, so only the first shifted-in bit is 1.
    quo_bit = (iter_q == 6'd0);
    trial   = {rem_q, quo_bit};
    diff    = trial - {1'b0, divisor_q};
    quo_nxt = {quo_q, !diff[PERIOD_W]};
    rem_nxt = diff[PERIOD_W] ? trial[PERIOD_W-1:0] : diff[PERIOD_W-1:0];

    div_start = pend_full_q && (div_q == DIV_IDLE);
    div_last  = (div_q == DIV_RUN) && (iter_q == LAST_IT);

    if (timeout) begin
      // Timeout wins: drop any pending period and abort the divide.
      period_d    = '0;
      phase_d     = '0;
      lock_d      = 1'b0;
      valid_d     = 1'b1;
      pend_full_d = 1'b0;
      div_d       = DIV_IDLE;
      meas_d      = SEEK;
    end else begin
      if (div_q == DIV_RUN) begin
        rem_d  = rem_nxt;
        quo_d  = quo_nxt[31:0];
        iter_d = iter_q + 6'd1;
        if (div_last) begin
          div_d    = DIV_IDLE;
          period_d = divisor_q;
          phase_d  = quo_nxt[32] ? 32'hFFFF_FFFF : quo_nxt[31:0];
          valid_d  = 1'b1;
          lock_d   = 1'b1;
        end
      end
      if (div_start) begin
        div_d       = DIV_RUN;
        divisor_d   = pend_val_q;
        rem_d       = '0;
        quo_d       = '0;
        iter_d      = '0;
        pend_full_d = 1'b0;
      end
      if (crossing) begin
        if (meas_q == MEASURE) begin
          // A pending value that was just consumed by a start is not lost.
          if (pend_full_q && !div_start) overrun_d = 1'b1;
          pend_full_d = 1'b1;
          pend_val_d  = cnt_q;
        end else begin
          meas_d = MEASURE;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meas_q      <= SEEK;
      div_q       <= DIV_IDLE;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      pend_val_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      iter_q      <= '0;
      period_q    <= '0;
      phase_q     <= '0;
      valid_q     <= 1'b0;
      lock_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      meas_q      <= meas_d;
      div_q       <= div_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_val_q  <= pend_val_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      iter_q      <= iter_d;
      period_q    <= period_d;
      phase_q     <= phase_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      overrun_q   <= overrun_d;
    end
  end

  assign period_out     = period_q;
  assign phase_incr_out = phase_q;
  assign valid_out      = valid_q;
  assign lock_out       = lock_q;
  assign busy_out       = (div_q == DIV_RUN);
  assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_phase_incr_estimator.sv
// Randomised bench for phase_incr_estimator. A reference model at posedge
// derives crossings/periods from the sample rules and predicts each output
// update (with its edge number); a negedge monitor pops and compares.
module tb_phase_incr_estimator;
  localparam int PW   = 16;
  localparam int MAXP = 300;
  localparam int HY   = 2**24;

  logic               clk = 1'b0;
  logic               rst, step;
  logic signed [31:0] sample;
  logic [PW-1:0]      period_out;
  logic [31:0]        phase_incr_out;
  logic               valid_out, lock_out, busy_out, overrun_out;

  phase_incr_estimator #(.PERIOD_W(PW), .MAX_PERIOD(MAXP), .HYST(HY)) dut (
    .clk_in(clk), .rst_in(rst), .step_in(step), .sample_in(sample),
    .period_out(period_out), .phase_incr_out(phase_incr_out),
    .valid_out(valid_out), .lock_out(lock_out), .busy_out(busy_out),
    .overrun_out(overrun_out)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int unsigned tag; longint per; longint inc; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit          m_armed, m_meas, m_pend, m_busy, m_lock, m_ovr;
  bit          m_fin, m_start, m_cross, m_tmo;
  int          m_cnt, m_prev, m_nxt, m_pval, m_dper;
  int unsigned m_dend, edge_n = 0;

  function automatic longint ref_inc(input longint p);
    longint r;
    r = (64'sd1 <<< 32) / p;
    return (r > 64'sh0FFFF_FFFF) ? 64'sh0FFFF_FFFF : r;
  endfunction

  always begin
    @(posedge clk);
    edge_n++;
    if (rst) begin
      m_armed = 0; m_meas = 0; m_pend = 0; m_busy = 0; m_lock = 0; m_ovr = 0;
      m_cnt = 0; exp_q.delete();
    end else begin
      m_fin   = m_busy && (edge_n == m_dend);
      m_start = m_pend && !m_busy;
      m_cross = 0; m_tmo = 0; m_prev = m_cnt;
      if (step) begin
        m_cross = m_armed && (sample >= 0);
        m_nxt   = (m_cnt >= MAXP) ? MAXP : m_cnt + 1;
        m_tmo   = m_meas && !m_cross && (m_nxt == MAXP);
        m_cnt   = m_cross ? 1 : m_nxt;
        if (m_cross) m_armed = 0;
        else if (sample < -HY) m_armed = 1;
      end
      if (m_tmo) begin
        exp_q.push_back('{edge_n, 0, 0});
        m_lock = 0; m_busy = 0; m_pend = 0; m_meas = 0;
      end else begin
        if (m_fin) begin
          exp_q.push_back('{edge_n, longint'(m_dper), ref_inc(longint'(m_dper))});
          m_lock = 1; m_busy = 0;
        end
        if (m_start) begin
          m_busy = 1; m_dper = m_pval; m_dend = edge_n + 33; m_pend = 0;
        end
        if (m_cross) begin
          if (m_meas) begin
            if (m_pend) m_ovr = 1;
            m_pend = 1; m_pval = m_prev;
          end else m_meas = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always begin
    exp_t e;
    @(negedge clk);
    checks++;
    if (valid_out !== (exp_q.size() > 0)) begin
      errors++;
      $display("FAIL valid @edge %0d: got %b expected %b", edge_n, valid_out, exp_q.size() > 0);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (valid_out === 1'b1) begin
        checks++;
        if (longint'(period_out) != e.per || longint'(phase_incr_out) != e.inc || e.tag != edge_n) begin
          errors++;
          $display("FAIL result @edge %0d: got per=%0d inc=%h expected per=%0d inc=%h (edge %0d)",
                   edge_n, period_out, phase_incr_out, e.per, e.inc, e.tag);
        end
      end
    end
    checks++;
    if (lock_out !== m_lock || busy_out !== m_busy || overrun_out !== m_ovr) begin
      errors++;
      $display("FAIL flags @edge %0d: got lock=%b busy=%b ovr=%b expected lock=%b busy=%b ovr=%b",
               edge_n, lock_out, busy_out, overrun_out, m_lock, m_busy, m_ovr);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] phase;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick(input bit r, input bit s, input logic [31:0] smp);
    rst = r; step = s; sample = smp;
    @(negedge clk);
  endtask

  // Sawtooth oscillator: one step every 'gap' clocks; idle clocks carry junk samples.
  task automatic saw(input logic [31:0] inc, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(0, 1, phase);
      phase = phase + inc;
      for (int g = 1; g < gap; g++) tick(0, 0, $urandom);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " period"}, longint'(period_out), 0);
    chk({nm, " phase"}, longint'(phase_incr_out), 0);
    chk({nm, " flags"}, longint'({valid_out, lock_out, busy_out, overrun_out}), 0);
  endtask

  initial begin
    logic [31:0] rip;
    bit seen;
    phase = '0;
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 1, 32'h8000_0000);
    chk_zero("reset");

    // Period 16
    saw(32'h1000_0000, 200, 1);
    chk("t1 period", longint'(period_out), 16);
    chk("t1 phase", longint'(phase_incr_out), 64'h1000_0000);
    chk("t1 lock", longint'(lock_out), 1);

    // Ripple between crossings, period 20
    for (int p = 0; p < 10; p++)
      for (int k = 0; k < 20; k++) begin
        rip = $urandom_range(0, 1 << 20);
        if (k == 0)      tick(0, 1, 32'h0);
        else if (k < 10) tick(0, 1, $urandom_range(0, 1) ? rip : -rip);
        else             tick(0, 1, -(32'sd1 <<< 29));
      end
    tick(0, 0, 0);
    chk("t4 period", longint'(period_out), 20);
    chk("t4 phase", longint'(phase_incr_out), 64'h0CCC_CCCC);

    // Period 3 with overruns
    phase = '0;
    saw(32'h5555_5556, 150, 1);
    chk("t2 period", longint'(period_out), 3);
    chk("t2 phase", longint'(phase_incr_out), 64'h5555_5555);
    chk("t2 overrun", longint'(overrun_out), 1);

    // Step every 4th clock, period 32
    saw(32'h0800_0000, 256, 4);
    chk("t5 period", longint'(period_out), 32);
    chk("t5 phase", longint'(phase_incr_out), 64'h0800_0000);

    // Lock at 16 then flat signal -> timeout
    saw(32'h1000_0000, 100, 1);
    chk("t3 pre period", longint'(period_out), 16);
    for (int i = 0; i < MAXP + 10; i++) tick(0, 1, 32'd1000);
    chk("t3 period", longint'(period_out), 0);
    chk("t3 phase", longint'(phase_incr_out), 0);
    chk("t3 lock", longint'(lock_out), 0);

    // Reset mid-divide
    phase = '0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      saw(32'h1000_0000, 1, 1);
      seen = busy_out;
    end
    chk("t6 busy seen", longint'(seen), 1);
    for (int i = 0; i < 9; i++) saw(32'h1000_0000, 1, 1);
    tick(1, 0, 0);
    chk_zero("t6 reset");
    phase = '0;
    saw(32'h1000_0000, 80, 1);

    // Random oscillators
    for (int s = 0; s < 4; s++)
      saw($urandom_range(32'd53687091, 32'h4000_0000), 120, $urandom_range(1, 3));

    for (int i = 0; i < 60; i++) tick(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
